// File: rtl/tt_um_mac_opgen.sv
// tt_um_mac_opgen: buffers DEPTH A/B operand pairs written bytewise and replays them under valid/ready.
// Optional MAC_OPGEN_LOOP_EN: playback wraps continuously with a one-cycle done pulse per pass.
module tt_um_mac_opgen #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  localparam int N = 2 * DEPTH;
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  state_t st, st_n;
  logic [PTR_W:0] wp, wp_n, len;
  logic [PTR_W-1:0] rp, rp_n;
  logic [7:0] mem [N];
  logic [7:0] uo_q;
  logic start_q, valid_q, phase_q, done_q, done_n, we, full, start_e, last;
  logic wr, start, ready, clear;
  logic unused_ok;
  assign wr = uio_in[4];
  assign start = uio_in[5];
  assign ready = uio_in[6];
  assign clear = uio_in[7];
  assign unused_ok = &{1'b0, uio_in[3:0]};
  assign start_e = start & ~start_q;
  assign full = wp == (PTR_W+1)'(N);
  // an odd trailing byte has no partner and is never played
  assign len = {wp[PTR_W:1], 1'b0};
  assign last = {1'b0, rp} == len - (PTR_W+1)'(1);
  assign uo_out = uo_q;
  assign uio_out = {4'b0, full, done_q, phase_q, valid_q};
  assign uio_oe = 8'h0F;
  always_comb begin
    st_n = st;
    wp_n = wp;
    rp_n = rp;
    done_n = done_q;
    we = 1'b0;
    if (clear) begin
      st_n = IDLE;
      wp_n = '0;
      rp_n = '0;
      done_n = 1'b0;
    end else if (start_e && st != PLAY && wp >= (PTR_W+1)'(2)) begin
      st_n = PLAY;
      rp_n = '0;
      done_n = 1'b0;
    end else if (wr && st != PLAY && !full) begin
      we = 1'b1;
      wp_n = wp + (PTR_W+1)'(1);
    end else if (st == PLAY) begin
      done_n = 1'b0;
      if (ready) begin
        done_n = last;
`ifdef MAC_OPGEN_LOOP_EN
        rp_n = last ? '0 : rp + PTR_W'(1);
`else
        rp_n = rp + PTR_W'(1);
        st_n = last ? DONE : PLAY;
`endif
      end
    end
  end
  // outputs are registered from next-state values so a start edge presents byte 0 immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      wp <= '0;
      rp <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      phase_q <= 1'b0;
      done_q <= 1'b0;
      uo_q <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (ena) begin
      st <= st_n;
      wp <= wp_n;
      rp <= rp_n;
      start_q <= start;
      done_q <= done_n;
      valid_q <= st_n == PLAY;
      phase_q <= st_n == PLAY && rp_n[0];
      uo_q <= st_n == PLAY ? mem[rp_n] : uo_q;
      if (we) mem[wp[PTR_W-1:0]] <= ui_in;
    end
  end
endmodule

// File: tb/tb_tt_um_mac_opgen.sv
// tb_tt_um_mac_opgen: table-driven and directed checks of the operand sequencer.
module tb_tt_um_mac_opgen;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = '0, uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0, errors = 0;
  typedef struct {
    logic w, s, r, c;
    logic [7:0] d;
    logic v, ph, dn, fl;
    logic [7:0] uo;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] ld [8] = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd5, 8'd3, 8'd7, 8'd2};
  tt_um_mac_opgen dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic s, input logic r, input logic c, input logic [7:0] d);
    ui_in = d;
    uio_in = {c, r, s, w, 4'b0};
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string nm, input logic v, input logic ph, input logic dn, input logic fl, input logic [7:0] uo);
    chk({nm, ".valid"}, uio_out[0], v);
    chk({nm, ".done"}, uio_out[2], dn);
    chk({nm, ".full"}, uio_out[3], fl);
    chk({nm, ".hi"}, uio_out[7:4], 0);
    if (v) begin
      chk({nm, ".uo"}, uo_out, uo);
      chk({nm, ".phase"}, uio_out[1], ph);
    end
  endtask
  initial begin
    #12;
    chk("rst.uo", uo_out, 0);
    chk("rst.uio_out", uio_out, 0);
    chk("rst.uio_oe", uio_oe, 8'h0F);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    expect_out("idle", 0, 0, 0, 0, 0);
`ifdef MAC_OPGEN_LOOP_EN
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 2);
    cyc(1, 0, 0, 0, 2);
    cyc(0, 1, 1, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      expect_out($sformatf("loop%0d", k), 1, (k - 1) % 2 == 1, k > 1 && (k - 1) % 4 == 0, 0, ((k - 1) % 4) < 2 ? 8'd1 : 8'd2);
      cyc(0, 0, 1, 0, 0);
    end
    cyc(0, 0, 1, 1, 0);
    expect_out("loop.clear", 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    expect_out("loop.stopped", 0, 0, 0, 0, 0);
`else
    for (int i = 0; i < 8; i++) tbl.push_back('{1, 0, 0, 0, ld[i], 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0, 0, 3});
    for (int i = 1; i < 8; i++) tbl.push_back('{0, 0, 1, 0, 0, 1, i[0], 0, 0, ld[i]});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0, 0, 3});
    for (int i = 1; i < 8; i++) begin
      tbl.push_back('{0, 0, 1, 0, 0, 1, i[0], 0, 0, ld[i]});
      if (i == 2) repeat (3) tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, ld[2]});
    end
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 1, 0, 0});
    foreach (tbl[k]) begin
      cyc(tbl[k].w, tbl[k].s, tbl[k].r, tbl[k].c, tbl[k].d);
      expect_out($sformatf("vec%0d", k), tbl[k].v, tbl[k].ph, tbl[k].dn, tbl[k].fl, tbl[k].uo);
    end
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 0, 0, 8'(10 + i));
      chk($sformatf("fill%0d.full", i), uio_out[3], i >= 15);
    end
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      expect_out($sformatf("full%0d", i), 1, i[0], 0, 1, 8'(10 + i));
      cyc(0, 0, 1, 0, 0);
    end
    expect_out("full.end", 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    expect_out("odd.clear", 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 9);
    cyc(1, 0, 0, 0, 8);
    cyc(1, 0, 0, 0, 6);
    cyc(0, 1, 1, 0, 0);
    expect_out("odd0", 1, 0, 0, 0, 9);
    cyc(0, 0, 1, 0, 0);
    expect_out("odd1", 1, 1, 0, 0, 8);
    cyc(0, 0, 1, 0, 0);
    expect_out("odd.end", 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 5);
    cyc(0, 1, 1, 0, 0);
    expect_out("one.start", 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    expect_out("one.idle", 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 0, 8'(i));
    cyc(0, 1, 1, 0, 0);
    expect_out("mid0", 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    expect_out("mid1", 1, 1, 0, 0, 2);
    cyc(0, 0, 1, 0, 0);
    expect_out("mid2", 1, 0, 0, 0, 3);
    cyc(0, 0, 1, 1, 0);
    expect_out("mid.clear", 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    expect_out("mid.nostart", 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 7);
    cyc(1, 0, 0, 0, 8);
    cyc(0, 1, 1, 0, 0);
    expect_out("reload0", 1, 0, 0, 0, 7);
    ena = 1'b0;
    cyc(0, 0, 1, 0, 0);
    expect_out("ena0.a", 1, 0, 0, 0, 7);
    cyc(0, 0, 1, 0, 0);
    expect_out("ena0.b", 1, 0, 0, 0, 7);
    ena = 1'b1;
    cyc(0, 0, 1, 0, 0);
    expect_out("reload1", 1, 1, 0, 0, 8);
    rst_n = 1'b0;
    #1;
    chk("arst.uo", uo_out, 0);
    chk("arst.uio_out", uio_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0, 0);
    expect_out("arst.idle", 0, 0, 0, 0, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
